// File: rtl/pc_sequencer.sv
// Program-counter / next-address stage: picks the next fetch address from jumpType,
// holds Z/C flags and a return-address stack for jsb/ret.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [2:0]                     jumpType,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           flag_we,
  input  logic                           alu_zero,
  input  logic                           alu_cout,
  output logic [ADDR_W-1:0]              pc,
  output logic                           taken,
  output logic                           zero_flag,
  output logic                           carry_flag,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = PTR_W + 1;

  localparam logic [2:0] JT_NONE = 3'b000;
  localparam logic [2:0] JT_BZ   = 3'b001;
  localparam logic [2:0] JT_BNZ  = 3'b010;
  localparam logic [2:0] JT_BC   = 3'b011;
  localparam logic [2:0] JT_BNC  = 3'b100;
  localparam logic [2:0] JT_JMP  = 3'b101;
  localparam logic [2:0] JT_JSB  = 3'b110;
  localparam logic [2:0] JT_RET  = 3'b111;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] ret_addr;
  logic [SP_W-1:0]   sp_dec;
  logic              stack_full;
  logic              stack_empty;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  assign pc_inc      = pc + ADDR_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign sp_dec      = sp - SP_W'(1);
  // Only consumed on a pop, which requires sp > 0, so the index is always a live entry.
  assign ret_addr    = stack_mem[sp_dec[PTR_W-1:0]];

  // Next-address decode; branches see the flags as registered before this edge.
  always_comb begin
    taken   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    next_pc = pc_inc;
    case (jumpType)
      JT_BZ:  taken = zero_flag;
      JT_BNZ: taken = ~zero_flag;
      JT_BC:  taken = carry_flag;
      JT_BNC: taken = ~carry_flag;
      JT_JMP: taken = 1'b1;
      JT_JSB: begin
        taken   = 1'b1;
        push    = ~stack_full;
        ovf_set = stack_full;
      end
      JT_RET: begin
        if (stack_empty) begin
          unf_set = 1'b1;
        end else begin
          taken = 1'b1;
          pop   = 1'b1;
        end
      end
      JT_NONE: ;
      default: ;
    endcase
    if (taken) begin
      next_pc = pop ? ret_addr : target;
    end
  end

  // Architectural state; stall freezes everything, reset overrides stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      sp         <= '0;
      stack_ovf  <= 1'b0;
      stack_unf  <= 1'b0;
    end else if (!stall) begin
      pc <= next_pc;
      if (flag_we) begin
        zero_flag  <= alu_zero;
        carry_flag <= alu_cout;
      end
      if (push) begin
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp_dec;
      end
      if (ovf_set) stack_ovf <= 1'b1;
      if (unf_set) stack_unf <= 1'b1;
    end
  end

  // Return-address storage is not reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (rst_n && !stall && push) begin
      stack_mem[sp[PTR_W-1:0]] <= pc_inc;
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and next-address stage that consumes the 3-bit jumpType produced by the opcode decoder.
- Holds the PC, the Z/C condition flags and an internal return-address stack for jsb/ret.
- Every unstalled clock it selects the next fetch address: sequential, conditional branch, jump, call or return.
- Its pc output drives the instruction-memory address.

Parameters:
- ADDR_W, 12, PC / target address width in bits.
- STACK_DEPTH, 8, number of return-address entries (power of 2, ≥2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  1 = hold all state this cycle.
- jumpType  in  3  000 none, 001 br-zero, 010 br-not-zero, 011 br-cout, 100 br-not-cout, 101 jmp, 110 jsb, 111 ret.
- target  in  ADDR_W  branch/jump/call destination from the instruction.
- flag_we  in  1  capture alu_zero/alu_cout into the flag register.
- alu_zero  in  1  ALU zero result.
- alu_cout  in  1  ALU carry-out result.
- pc  out  ADDR_W  current fetch address (registered).
- taken  out  1  combinational; 1 when next PC ≠ pc+1 due to control flow.
- zero_flag  out  1  registered Z.
- carry_flag  out  1  registered C.
- sp  out  $clog2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH.
- stack_ovf  out  1  sticky overflow error.
- stack_unf  out  1  sticky underflow error.

Behaviour:
- Reset: on rising clk with rst_n=0, regardless of stall:
  - pc=RESET_PC, zero_flag=0, carry_flag=0, sp=0, stack_ovf=0, stack_unf=0.
  - Stack RAM contents are not reset and are never read while sp=0.
  - Reset mid-call discards all pending return addresses.
- Stall: when stall=1 no register changes, including pc, flags, sp, stack and error bits. taken is still computed combinationally.
- Sequential increment: pc_inc = pc+1 modulo 2^ADDR_W, wrapping from all-ones to 0.
- Next-PC selection (unstalled cycle):
  - 000: pc_inc.
  - 001: target if zero_flag=1, else pc_inc.
  - 010: target if zero_flag=0, else pc_inc.
  - 011: target if carry_flag=1, else pc_inc.
  - 100: target if carry_flag=0, else pc_inc.
  - 101: target.
  - 110 (jsb), sp<STACK_DEPTH: write pc_inc to entry[sp], sp+=1, pc=target.
  - 110 (jsb), sp==STACK_DEPTH: no write, sp unchanged, stack_ovf<=1, pc=target.
  - 111 (ret), sp>0: pc=entry[sp-1], sp-=1.
  - 111 (ret), sp==0: pc=pc_inc, stack_unf<=1.
- Branch flag timing:
  - Branches test the registered flags as they stand before the current edge.
  - A flag_we in the same cycle as a branch affects only later branches.
- Flags: if flag_we=1 and stall=0, zero_flag<=alu_zero and carry_flag<=alu_cout. Otherwise both hold. Flag capture is independent of jumpType.
- taken: 1 for 101, 110 and successful ret; 1 for a satisfied condition; 0 otherwise. An underflowing ret gives 0. taken is 1 whenever the condition holds, even if target==pc_inc.
- Error bits stack_ovf and stack_unf are sticky, cleared only by reset.
- Latency: jumpType/target sampled at edge N → new pc visible after edge N; one cycle, no bubbles.

Test Plan:
- Reset and increment: rst_n=0 for 2 cycles, then 5 cycles of jumpType=000 → pc 0,1,2,3,4,5; flags 0; sp 0. With ADDR_W=12 preload pc=0xFFF, jumpType=000 → pc=0x000.
- Conditional branch with same-cycle flag write: flag_we=1, alu_zero=1, jumpType=000 at pc=3 → pc=4, zero_flag=1. Then jumpType=001, target=0x40 → taken=1, pc=0x40. Then flag_we=1, alu_zero=0 together with jumpType=001, target=0x80 → pc=0x80 (old Z=1 used), zero_flag=0 afterwards. Branch on carry_flag=0 with jumpType=011 → pc increments, taken=0.
- Nested call/return: at pc=0x10 jsb target=0x100 → pc=0x100, sp=1. At 0x100 jsb target=0x200 → sp=2. ret → pc=0x101, sp=1. ret → pc=0x11, sp=0.
- Overflow then underflow: 9 consecutive jsb with STACK_DEPTH=8 → sp saturates at 8, stack_ovf=1 after the 9th, pc=target. Then 8 ret return in LIFO order. A 9th ret → pc=pc+1, stack_unf=1, taken=0, sp=0. Both errors stay set until reset.
- Stall: hold stall=1 for 3 cycles with jumpType=110, flag_we=1 → pc, sp, flags and stack unchanged. Release → exactly one push occurs.
- Reset mid-call: with sp=3, assert rst_n=0 together with stall=1 → pc=RESET_PC, sp=0, errors 0. A following ret raises stack_unf.
